// File: rtl/ntt_seq_pkg.sv
// Purpose: shared constants, state encoding and opcode helper for the NTT op sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ntt_seq_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 64;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_BFLY = 3'b011;
  localparam logic [2:0] OP_ROM  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_FETCH,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

  // 101..111 are reserved encodings.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= OP_ROM);
  endfunction

endpackage

// File: rtl/ntt_op_sequencer.sv
// Purpose: walks one vector command over the coefficient RAM through the NTT arithmetic unit.
// Latency: 4 cycles per element (READ/FETCH/EXEC/WRITE), DONE one cycle after the last WRITE.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is left unconsumed.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_*                            command handshake and fields (opcode, bases, length, w/q/mu)
//   rd_en, rd_addr_a/b, rd_data_a/b  dual-port RAM read, data one cycle after rd_en
//   wr_en_a/b, wr_addr_a/b, wr_data_a/b  RAM write ports (B only used by butterfly)
//   au_opcode, au_op_*, au_res_1/2   arithmetic unit operands and registered results
//   busy, done, err                  status: non-IDLE, one-cycle completion pulse, sticky illegal op
module ntt_op_sequencer
  import ntt_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_w,
  input  logic [DATA_W-1:0] cmd_q,
  input  logic [DATA_W-1:0] cmd_mu,

  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,

  output logic              wr_en_a,
  output logic              wr_en_b,
  output logic [ADDR_W-1:0] wr_addr_a,
  output logic [ADDR_W-1:0] wr_addr_b,
  output logic [DATA_W-1:0] wr_data_a,
  output logic [DATA_W-1:0] wr_data_b,

  output logic [2:0]        au_opcode,
  output logic [DATA_W-1:0] au_op_a,
  output logic [DATA_W-1:0] au_op_b,
  output logic [DATA_W-1:0] au_op_w,
  output logic [DATA_W-1:0] au_op_q,
  output logic [DATA_W-1:0] au_op_mu,
  input  logic [DATA_W-1:0] au_res_1,
  input  logic [DATA_W-1:0] au_res_2,

  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] ptr_a_q, ptr_b_q, cnt_q;
  logic [DATA_W-1:0] w_q, q_q, mu_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic              err_q;

  logic accept;
  logic last_elem;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  // Count still holds the pre-decrement value during WRITE.
  assign last_elem = (cnt_q == ADDR_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    wr_en_a   = 1'b0;
    wr_en_b   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (!is_legal_op(cmd_opcode) || (cmd_len == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        rd_en   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: begin
        // Illegal opcodes never reach WRITE, so port A always writes here.
        wr_en_a = 1'b1;
        wr_en_b = (op_q == OP_BFLY);
        state_d = last_elem ? ST_DONE : ST_READ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      ptr_a_q <= '0;
      ptr_b_q <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      q_q     <= '0;
      mu_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= cmd_opcode;
        ptr_a_q <= cmd_addr_a;
        ptr_b_q <= cmd_addr_b;
        cnt_q   <= cmd_len;
        w_q     <= cmd_w;
        q_q     <= cmd_q;
        mu_q    <= cmd_mu;
        err_q   <= !is_legal_op(cmd_opcode);
      end
      if (state_q == ST_FETCH) begin
        op_a_q <= rd_data_a;
        op_b_q <= rd_data_b;
      end
      if (state_q == ST_WRITE) begin
        // Natural wrap at 2^ADDR_W is intended.
        ptr_a_q <= ptr_a_q + ADDR_W'(1);
        ptr_b_q <= ptr_b_q + ADDR_W'(1);
        cnt_q   <= cnt_q - ADDR_W'(1);
      end
    end
  end

  // Address/data buses are zeroed outside their strobe so idle buses stay quiet.
  assign rd_addr_a = rd_en   ? ptr_a_q  : '0;
  assign rd_addr_b = rd_en   ? ptr_b_q  : '0;
  assign wr_addr_a = wr_en_a ? ptr_a_q  : '0;
  assign wr_data_a = wr_en_a ? au_res_1 : '0;
  assign wr_addr_b = wr_en_b ? ptr_b_q  : '0;
  assign wr_data_b = wr_en_b ? au_res_2 : '0;

  assign au_opcode = op_q;
  assign au_op_a   = op_a_q;
  assign au_op_b   = op_b_q;
  assign au_op_w   = w_q;
  assign au_op_q   = q_q;
  assign au_op_mu  = mu_q;

  assign err = err_q;

endmodule

// File: doc/ntt_op_sequencer.md
# ntt_op_sequencer

Command-driven initiator for the NTT arithmetic unit. It accepts one vector command (opcode, two base addresses, length, modulus constants) and walks the coefficient RAM element by element. For each element it reads operands A and B, drives them to the arithmetic unit, captures the registered result one cycle later, and writes it back in place. It sits between the host/command path and the arithmetic unit, owning the unit's operand bus and both RAM ports.

## Interface
- `ADDR_W`, default 10: coefficient RAM address width; also the width of `cmd_len`.
- `DATA_W`, default 64: coefficient and constant width.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake; a command is accepted on the edge where both are 1.
- `cmd_opcode` in 3: 000 add, 001 mult, 010 sub, 011 butterfly, 100 twiddle-ROM read; 101–111 illegal.
- `cmd_addr_a`, `cmd_addr_b` in `ADDR_W`: base addresses of the A and B vectors.
- `cmd_len` in `ADDR_W`: element count; 0 is legal.
- `cmd_w`, `cmd_q`, `cmd_mu` in `DATA_W`: twiddle, modulus and Barrett constant for the whole command.
- `rd_en` out 1, `rd_addr_a`, `rd_addr_b` out `ADDR_W`: dual-port read request.
- `rd_data_a`, `rd_data_b` in `DATA_W`: read data, valid exactly one cycle after `rd_en`.
- `wr_en_a`, `wr_en_b` out 1; `wr_addr_a`, `wr_addr_b` out `ADDR_W`; `wr_data_a`, `wr_data_b` out `DATA_W`: write ports.
- `au_opcode` out 3; `au_op_a`, `au_op_b`, `au_op_w`, `au_op_q`, `au_op_mu` out `DATA_W`: arithmetic unit operands.
- `au_res_1`, `au_res_2` in `DATA_W`: arithmetic unit registered results, valid one cycle after operands.
- `busy` out 1, `done` out 1 (single-cycle pulse), `err` out 1 (sticky).

## Operation
- States: IDLE, READ, FETCH, EXEC, WRITE, DONE.
- IDLE: `cmd_ready`=1.
  - On accept, latch the opcode, addresses, length and constants into registers, and clear `err`.
  - If the opcode is illegal, set `err` and go to DONE.
  - Else if `cmd_len`=0, go to DONE.
  - Otherwise go to READ.
- READ: `rd_en`=1, with the current A/B pointers on `rd_addr_a`/`rd_addr_b`.
- FETCH: register `rd_data_a`/`rd_data_b` into `au_op_a`/`au_op_b` at the end of the cycle.
- EXEC: operands are stable; the arithmetic unit samples them at the end of the cycle.
- WRITE:
  - Write `au_res_1` to the A pointer for every legal opcode.
  - Butterfly (011) also writes `au_res_2` to the B pointer.
  - Increment both pointers modulo 2^`ADDR_W` (wrap-around is legal) and decrement the remaining count.
  - Go to READ if the count is nonzero, else DONE.
- DONE: `done`=1 for this cycle only, then return to IDLE.
- `au_opcode`, `au_op_w`, `au_op_q`, `au_op_mu` are driven from the latched command and held until the next accept.
- `busy`=1 in every non-IDLE state.
- `cmd_valid` while busy is ignored; the command is not consumed.
- Illegal opcode or `cmd_len`=0: no read and no write occur.
- A/B address overlap is not checked; writes land in WRITE order.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE; all outputs 0 except `cmd_ready`=1. Registers cleared. Reset mid-command abandons it with no further writes.
- Accept at the end of cycle 0:
  - Element i: READ at cycle 4i+1, FETCH at 4i+2, EXEC at 4i+3, WRITE at 4i+4.
  - DONE at cycle 4N+1; IDLE with `cmd_ready`=1 at 4N+2.
- `cmd_len`=0 or illegal opcode: DONE at cycle 1.
- Throughput: one element per 4 cycles; no overlap between elements.
- `wr_en_*` are high only in WRITE; `rd_en` is high only in READ.

## Structure
- Shared package `ntt_seq_pkg` holds:
  - opcode constants (`OP_ADD`..`OP_ROM`) and the `is_legal_op` function,
  - the state enum,
  - the default `ADDR_W`/`DATA_W`.
- No sub-module: single FSM plus datapath registers. The arithmetic unit and RAM are instantiated by the parent.

## Test plan
- Add: q=17, A[0]=5, B[0]=14, len=1 → `wr_data_a`=2 at address 0 at cycle 4; `done` at cycle 5; `wr_en_b` never set.
- Butterfly: q=17, w=2, A[3]=3, B[7]=4, len=1 → A[3]=11 and B[7]=12 written in the same cycle.
- Vector with wrap: ADDR_W=4, addr_a=14, addr_b=0, len=4, sub → writes at A addresses 14, 15, 0, 1 on cycles 4, 8, 12, 16; `done` at cycle 17.
- Edge commands:
  - len=0 → `done` at cycle 1, `err`=0, no `rd_en`.
  - Opcode 101 → `done` at cycle 1, `err`=1 until the next accept.
- Busy and reset:
  - `cmd_valid` held high during a command → second command accepted only in the IDLE cycle after `done`.
  - `rst_n` pulsed low during EXEC of element 2 of 4 → outputs 0 immediately, `cmd_ready`=1, no further writes.
